// File: rtl/exec_pkg.sv
// Shared widths, ALU function codes and pipeline payload types for the execute stage.
package exec_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned REG_ADDR_W  = 5;
    localparam int unsigned OP_W        = 5;
    localparam int unsigned FN_W        = 4;
    localparam int unsigned SHAMT_W     = 5;
    localparam int unsigned IMM_SEL_BIT = 4;

    localparam logic [FN_W-1:0] FN_ADD   = 4'd0;
    localparam logic [FN_W-1:0] FN_SUB   = 4'd1;
    localparam logic [FN_W-1:0] FN_SLL   = 4'd2;
    localparam logic [FN_W-1:0] FN_SLT   = 4'd3;
    localparam logic [FN_W-1:0] FN_SLTU  = 4'd4;
    localparam logic [FN_W-1:0] FN_XOR   = 4'd5;
    localparam logic [FN_W-1:0] FN_SRL   = 4'd6;
    localparam logic [FN_W-1:0] FN_SRA   = 4'd7;
    localparam logic [FN_W-1:0] FN_OR    = 4'd8;
    localparam logic [FN_W-1:0] FN_AND   = 4'd9;
    localparam logic [FN_W-1:0] FN_PASSB = 4'd10;

    // Decode-to-execute register contents
    typedef struct packed {
        logic [DATA_W-1:0]     rs1;
        logic [DATA_W-1:0]     rs2;
        logic [DATA_W-1:0]     imm;
        logic [OP_W-1:0]       op;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wb_en;
        logic                  rd_en;
        logic                  wr_en;
    } s1_t;

    // Execute-to-memory register contents
    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic [DATA_W-1:0]     rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wb_en;
        logic                  rd_en;
        logic                  wr_en;
    } s2_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational RV32 ALU: operand-B select (rs2 or immediate) plus the function case.
module exec_alu
    import exec_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] rs2,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result_c
);

    logic [DATA_W-1:0]  b;
    logic [SHAMT_W-1:0] shamt;

    always_comb begin
        b        = op[IMM_SEL_BIT] ? imm : rs2;
        shamt    = b[SHAMT_W-1:0];
        result_c = '0;
        case (op[FN_W-1:0])
            FN_ADD:   result_c = a + b;
            FN_SUB:   result_c = a - b;
            FN_SLL:   result_c = a << shamt;
            FN_SLT:   result_c = DATA_W'($signed(a) < $signed(b));
            FN_SLTU:  result_c = DATA_W'(a < b);
            FN_XOR:   result_c = a ^ b;
            FN_SRL:   result_c = a >> shamt;
            FN_SRA:   result_c = DATA_W'($signed(a) >>> shamt);
            FN_OR:    result_c = a | b;
            FN_AND:   result_c = a & b;
            FN_PASSB: result_c = b;
            default:  result_c = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute slice: decode-to-execute register, ALU, execute-to-memory register (2-cycle latency).
// Optional EXEC_ZERO_FLAG_EN adds a registered zeroOut flag aligned with dataOut.
module execute_stage
    import exec_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetIn,
    input  logic [DATA_W-1:0]     dataReg1,
    input  logic [DATA_W-1:0]     dataReg2,
    input  logic [DATA_W-1:0]     immValueIn,
    input  logic [OP_W-1:0]       ALUop,
    input  logic [REG_ADDR_W-1:0] writeBackAddrIn,
    input  logic                  writeEnableReg,
    input  logic                  dataCacheReadEnableIn,
    input  logic                  dataCacheWriteEnableIn,
    output logic [DATA_W-1:0]     dataOut,
    output logic [DATA_W-1:0]     dataRs2Out,
    output logic                  writeEnableOut,
    output logic                  dataCacheReadEnableOut,
    output logic                  dataCacheWriteEnableOut,
    output logic [REG_ADDR_W-1:0] writeBackAddrOut
`ifdef EXEC_ZERO_FLAG_EN
    ,
    output logic                  zeroOut
`endif
);

    s1_t               s1_d, s1_q;
    s2_t               s2_d, s2_q;
    logic [DATA_W-1:0] alu_result_c;

    exec_alu u_alu (
        .op       (s1_q.op),
        .a        (s1_q.rs1),
        .rs2      (s1_q.rs2),
        .imm      (s1_q.imm),
        .result_c (alu_result_c)
    );

    always_comb begin
        s1_d       = '0;
        s1_d.rs1   = dataReg1;
        s1_d.rs2   = dataReg2;
        s1_d.imm   = immValueIn;
        s1_d.op    = ALUop;
        s1_d.rd    = writeBackAddrIn;
        s1_d.wb_en = writeEnableReg;
        s1_d.rd_en = dataCacheReadEnableIn;
        s1_d.wr_en = dataCacheWriteEnableIn;
    end

    // Store data always comes from rs2, independent of the immediate select
    always_comb begin
        s2_d        = '0;
        s2_d.result = alu_result_c;
        s2_d.rs2    = s1_q.rs2;
        s2_d.rd     = s1_q.rd;
        s2_d.wb_en  = s1_q.wb_en;
        s2_d.rd_en  = s1_q.rd_en;
        s2_d.wr_en  = s1_q.wr_en;
    end

    always_ff @(posedge clk) begin
        if (resetIn) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

`ifdef EXEC_ZERO_FLAG_EN
    logic zero_d, zero_q;

    always_comb begin
        zero_d = (alu_result_c == '0);
    end

    always_ff @(posedge clk) begin
        if (resetIn) zero_q <= 1'b0;
        else         zero_q <= zero_d;
    end

    assign zeroOut = zero_q;
`endif

    assign dataOut                 = s2_q.result;
    assign dataRs2Out              = s2_q.rs2;
    assign writeEnableOut          = s2_q.wb_en;
    assign dataCacheReadEnableOut  = s2_q.rd_en;
    assign dataCacheWriteEnableOut = s2_q.wr_en;
    assign writeBackAddrOut        = s2_q.rd;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: stimulus queues expected outputs with a due cycle,
// a monitor pops and compares them after each rising edge.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        resetIn = 1'b1;
    logic [31:0] dataReg1 = '0, dataReg2 = '0, immValueIn = '0;
    logic [4:0]  ALUop = '0, writeBackAddrIn = '0;
    logic        writeEnableReg = 1'b0, dataCacheReadEnableIn = 1'b0, dataCacheWriteEnableIn = 1'b0;
    logic [31:0] dataOut, dataRs2Out;
    logic        writeEnableOut, dataCacheReadEnableOut, dataCacheWriteEnableOut;
    logic [4:0]  writeBackAddrOut;
`ifdef EXEC_ZERO_FLAG_EN
    logic        zeroOut;
`endif

    execute_stage dut (
        .clk                     (clk),
        .resetIn                 (resetIn),
        .dataReg1                (dataReg1),
        .dataReg2                (dataReg2),
        .immValueIn              (immValueIn),
        .ALUop                   (ALUop),
        .writeBackAddrIn         (writeBackAddrIn),
        .writeEnableReg          (writeEnableReg),
        .dataCacheReadEnableIn   (dataCacheReadEnableIn),
        .dataCacheWriteEnableIn  (dataCacheWriteEnableIn),
        .dataOut                 (dataOut),
        .dataRs2Out              (dataRs2Out),
        .writeEnableOut          (writeEnableOut),
        .dataCacheReadEnableOut  (dataCacheReadEnableOut),
        .dataCacheWriteEnableOut (dataCacheWriteEnableOut),
        .writeBackAddrOut        (writeBackAddrOut)
`ifdef EXEC_ZERO_FLAG_EN
        ,
        .zeroOut                 (zeroOut)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        string       name;
        logic [31:0] data;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        we;
        logic        re;
        logic        wr;
        logic        zero;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd2, SLT = 5'd3, SLTU = 5'd4,
                           XOR = 5'd5, SRL = 5'd6, SRA = 5'd7, OR = 5'd8, AND = 5'd9,
                           PASSB = 5'd10, IMM = 5'd16;

    task automatic chk(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s cycle=%0d got=0x%08h expected=0x%08h", name, field, cyc, act, req);
        end
    endtask

    // Monitor: compare every expectation that falls due on this edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (q.size() > 0 && q[0].due <= cyc) begin
                exp_t e;
                e = q.pop_front();
                if (e.due < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL %s missed due=%0d now=%0d", e.name, e.due, cyc);
                end else begin
                    chk(e.name, "dataOut", dataOut, e.data);
                    chk(e.name, "dataRs2Out", dataRs2Out, e.rs2);
                    chk(e.name, "wbAddr", 32'(writeBackAddrOut), 32'(e.rd));
                    chk(e.name, "wbEn", 32'(writeEnableOut), 32'(e.we));
                    chk(e.name, "rdEn", 32'(dataCacheReadEnableOut), 32'(e.re));
                    chk(e.name, "wrEn", 32'(dataCacheWriteEnableOut), 32'(e.wr));
`ifdef EXEC_ZERO_FLAG_EN
                    chk(e.name, "zeroOut", 32'(zeroOut), 32'(e.zero));
`endif
                end
            end
        end
    end

    // One instruction per cycle; expected result supplied by hand
    task automatic issue(input string name, input logic [4:0] op, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic [4:0] rd,
                         input logic we, input logic re, input logic wr, input logic [31:0] exp_data);
        exp_t e;
        @(negedge clk);
        resetIn = 1'b0;
        ALUop = op; dataReg1 = rs1; dataReg2 = rs2; immValueIn = imm;
        writeBackAddrIn = rd; writeEnableReg = we;
        dataCacheReadEnableIn = re; dataCacheWriteEnableIn = wr;
        e.due = cyc + 2; e.name = name; e.data = exp_data; e.rs2 = rs2; e.rd = rd;
        e.we = we; e.re = re; e.wr = wr; e.zero = (exp_data == 32'd0);
        q.push_back(e);
    endtask

    // Reset edge with busy inputs: anything still in flight is dropped, outputs read zero
    task automatic reset_cycle(input string name);
        exp_t e;
        @(negedge clk);
        resetIn = 1'b1;
        ALUop = ADD; dataReg1 = 32'hA5A5_0001; dataReg2 = 32'h5A5A_0002; immValueIn = 32'h0000_0FFF;
        writeBackAddrIn = 5'd31; writeEnableReg = 1'b1;
        dataCacheReadEnableIn = 1'b1; dataCacheWriteEnableIn = 1'b1;
        while (q.size() > 0 && q[$].due >= cyc + 1) void'(q.pop_back());
        for (int k = 1; k <= 2; k++) begin
            e.due = cyc + k; e.name = name; e.data = '0; e.rs2 = '0; e.rd = '0;
            e.we = 1'b0; e.re = 1'b0; e.wr = 1'b0; e.zero = 1'b0;
            q.push_back(e);
        end
    endtask

    initial begin
        reset_cycle("rst_a");
        reset_cycle("rst_b");
        issue("add_5_7",    ADD,         32'd5,          32'd7,          32'd0,          5'd1, 1, 0, 0, 32'd12);
        issue("addi_neg",   IMM | ADD,   32'h100,        32'h55,         32'hFFFF_FFFC,  5'd2, 1, 0, 0, 32'hFC);
        issue("lui_passb",  IMM | PASSB, 32'hAAAA,       32'h0,          32'h1234_5000,  5'd4, 1, 0, 0, 32'h1234_5000);
        issue("subi",       IMM | SUB,   32'd10,         32'd100,        32'd3,          5'd5, 1, 0, 0, 32'd7);
        issue("slt",        SLT,         32'hFFFF_FFFF,  32'd1,          32'd0,          5'd6, 1, 0, 0, 32'd1);
        issue("sltu",       SLTU,        32'hFFFF_FFFF,  32'd1,          32'd0,          5'd7, 1, 0, 0, 32'd0);
        issue("sra",        SRA,         32'h8000_0000,  32'h24,         32'd0,          5'd8, 1, 0, 0, 32'hF800_0000);
        issue("srl",        SRL,         32'h8000_0000,  32'h24,         32'd0,          5'd9, 1, 0, 0, 32'h0800_0000);
        issue("sll",        SLL,         32'd1,          32'h21,         32'd0,          5'd10, 1, 0, 0, 32'd2);
        issue("or",         OR,          32'hF0,         32'h0F,         32'd0,          5'd11, 1, 0, 0, 32'hFF);
        issue("store",      IMM | ADD,   32'h20,         32'hDEAD_BEEF,  32'd8,          5'd3, 0, 0, 1, 32'h28);
        issue("load_rw",    IMM | ADD,   32'h1000,       32'h77,         32'h10,         5'd0, 1, 1, 1, 32'h1010);
        issue("fn12_zero",  5'd12,       32'd5,          32'd6,          32'd0,          5'd12, 1, 0, 0, 32'd0);
        issue("s_add",      ADD,         32'd1,          32'd2,          32'd0,          5'd13, 1, 0, 0, 32'd3);
        issue("s_sub",      SUB,         32'd1,          32'd2,          32'd0,          5'd14, 1, 0, 0, 32'hFFFF_FFFF);
        issue("s_xor",      XOR,         32'hF0,         32'hFF,         32'd0,          5'd15, 1, 0, 0, 32'h0F);
        issue("s_and",      AND,         32'hF0,         32'h3C,         32'd0,          5'd16, 1, 0, 0, 32'h30);
        issue("s_x",        ADD,         32'd40,         32'd2,          32'd0,          5'd17, 1, 0, 0, 32'd42);
        issue("s_lost",     ADD,         32'd100,        32'd200,        32'd0,          5'd18, 1, 1, 1, 32'd300);
        reset_cycle("rst_mid");
        issue("post_rst",   ADD,         32'h11,         32'h22,         32'd0,          5'd19, 1, 0, 0, 32'h33);
        issue("sub_9_9",    SUB,         32'd9,          32'd9,          32'd0,          5'd20, 1, 0, 0, 32'd0);
        issue("add_1_0",    ADD,         32'd1,          32'd0,          32'd0,          5'd21, 1, 0, 0, 32'd1);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
